// File: rtl/lut_neuron_array_ld.sv
// Array of N_CH runtime-loadable truth-table neurons behind a registered valid/ready stage.
// Tables are streamed in through the cfg_* port; lookups stall while a table is (re)loaded.
//
// state | meaning
// IDLE  | no valid table since reset, datapath closed
// DRAIN | reload requested, waiting for the pending result to leave
// LOAD  | streaming table entries, counter selects channel/index
// RUN   | table valid, lookups accepted
module lut_neuron_array_ld #(
  parameter int IN_BITS  = 8,
  parameter int OUT_BITS = 1,
  parameter int N_CH     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_start,
  input  logic                     cfg_valid,
  input  logic [OUT_BITS-1:0]      cfg_data,
  output logic                     cfg_busy,
  output logic                     tbl_ready,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [N_CH*IN_BITS-1:0]  in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_CH*OUT_BITS-1:0] out_data
);

  localparam int CW      = $clog2(N_CH) + IN_BITS;
  localparam int DEPTH   = 1 << IN_BITS;
  localparam int ENTRIES = N_CH * DEPTH;
  localparam logic [CW-1:0] LAST = CW'(ENTRIES - 1);

  typedef enum logic [1:0] {IDLE, DRAIN, LOAD, RUN} state_t;

  state_t                   state;
  logic [CW-1:0]            count;
  logic [OUT_BITS-1:0]      mem [ENTRIES];
  logic [N_CH*OUT_BITS-1:0] lookup;
  logic                     wr_en;
  logic                     accept;

  assign in_ready = (state == RUN) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign cfg_busy = (state == DRAIN) || (state == LOAD);
  // A restart in the same cycle as an entry discards that entry.
  assign wr_en    = (state == LOAD) && cfg_valid && !cfg_start;

  // The counter value is channel*DEPTH + index, so it addresses the flat table directly.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count] <= cfg_data;
  end

  always_comb begin
    lookup = '0;
    for (int c = 0; c < N_CH; c++) begin
      lookup[c*OUT_BITS +: OUT_BITS] =
        mem[CW'(c * DEPTH) + CW'(in_data[c*IN_BITS +: IN_BITS])];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      count     <= '0;
      tbl_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_start) begin
            state     <= LOAD;
            count     <= '0;
            tbl_ready <= 1'b0;
          end
        end
        RUN: begin
          if (cfg_start) state <= DRAIN;
        end
        DRAIN: begin
          if (!out_valid || out_ready) begin
            state     <= LOAD;
            count     <= '0;
            tbl_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (cfg_start) begin
            count <= '0;
          end else if (cfg_valid) begin
            if (count == LAST) begin
              state     <= RUN;
              tbl_ready <= 1'b1;
            end else begin
              count <= count + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lookup;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lut_neuron_array_ld.sv
// Randomized bench for lut_neuron_array_ld with a behavioural table/queue model
// checked on every negedge, plus literal expectations for the default table.
module tb_lut_neuron_array_ld;
  localparam int IN_BITS = 8, OUT_BITS = 1, N_CH = 4;
  localparam int DEPTH = 256, ENTRIES = 1024;

  logic        clk = 0, rst_n = 1, cfg_start = 0, cfg_valid = 0;
  logic [0:0]  cfg_data = '0;
  logic        cfg_busy, tbl_ready, in_ready, out_valid;
  logic        in_valid = 0, out_ready = 0;
  logic [31:0] in_data = '0;
  logic [3:0]  out_data;

  int total = 0, bad = 0, n_out = 0;
  bit mon_on = 0;

  typedef enum {M_IDLE, M_DRAIN, M_LOAD, M_RUN} mph_t;
  mph_t mph = M_IDLE;
  int   mcnt = 0;
  bit   mtbl [N_CH][DEPTH];
  logic [3:0] q[$];
  bit   prev_stall = 0;
  logic [3:0] prev_data = '0;

  lut_neuron_array_ld #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS), .N_CH(N_CH)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_data(cfg_data),
    .cfg_busy(cfg_busy), .tbl_ready(tbl_ready),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_lookup(logic [31:0] d);
    logic [3:0] r;
    r = '0;
    for (int c = 0; c < N_CH; c++) begin
      int code;
      code = int'((d >> (8 * c)) & 32'hFF);
      r[c] = mtbl[c][code];
    end
    return r;
  endfunction

  // Reference model: spec-level phase, load counter, table array and a result queue.
  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst_n) begin
        mph = M_IDLE; mcnt = 0; q.delete(); prev_stall = 0;
        chk("rst_outs", {in_ready, out_valid, tbl_ready, cfg_busy, out_data}, 0);
      end else begin
        chk("in_ready", in_ready, (mph == M_RUN) && (!out_valid || out_ready));
        chk("tbl_ready", tbl_ready, mph == M_RUN || mph == M_DRAIN);
        chk("cfg_busy", cfg_busy, mph == M_DRAIN || mph == M_LOAD);
        chk("out_valid", out_valid, q.size() != 0);
        if (prev_stall) chk("stall_hold", out_data, prev_data);
        if (out_valid && out_ready && q.size() != 0) begin
          chk("out_data", out_data, q.pop_front());
          n_out++;
        end
        if (in_valid && in_ready) q.push_back(model_lookup(in_data));
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        case (mph)
          M_IDLE:  if (cfg_start) begin mph = M_LOAD; mcnt = 0; end
          M_RUN:   if (cfg_start) mph = M_DRAIN;
          M_DRAIN: if (!out_valid || out_ready) begin mph = M_LOAD; mcnt = 0; end
          M_LOAD: begin
            if (cfg_start) mcnt = 0;
            else if (cfg_valid) begin
              mtbl[mcnt / DEPTH][mcnt % DEPTH] = cfg_data[0];
              mcnt++;
              if (mcnt == ENTRIES) mph = M_RUN;
            end
          end
          default: mph = M_IDLE;
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic feed(int n, bit rnd, int base);
    int i;
    i = 0;
    while (i < n) begin
      if (rnd && $urandom_range(3) == 0) cfg_valid = 0;
      else begin
        int k;
        k = base + i;
        cfg_valid = 1;
        cfg_data  = rnd ? 1'($urandom_range(1)) : 1'(((k % DEPTH) >> (k / DEPTH)) & 1);
        i++;
      end
      step();
    end
    cfg_valid = 0;
  endtask

  task automatic start_load();
    int g;
    g = 0;
    out_ready = 1;
    cfg_start = 1; step(); cfg_start = 0;
    while (!(cfg_busy && !tbl_ready) && g < 50) begin step(); g++; end
    chk("enter_load", {cfg_busy, tbl_ready}, 2'b10);
  endtask

  task automatic traffic(int n);
    for (int k = 0; k < n; k++) begin
      in_valid  = 1'($urandom_range(1));
      in_data   = $urandom();
      out_ready = ($urandom_range(3) != 0);
      step();
    end
    in_valid = 0; out_ready = 1;
    step(); step();
  endtask

  logic [31:0] lit_in  [4] = '{32'h0FA53C81, 32'h08040201, 32'h00FF00FF, 32'h00000000};
  logic [3:0]  lit_out [4] = '{4'b1101, 4'b1111, 4'b0101, 4'b0000};

  initial begin
    int acc, cyc, n0;
    bit a;
    #13 rst_n = 0;
    #1 chk("rst_async", {in_ready, out_valid, tbl_ready, cfg_busy, out_data}, 0);
    mon_on = 1;
    step(); step(); rst_n = 1;

    in_valid = 1; out_ready = 1;
    for (int k = 0; k < 20; k++) begin
      in_data = $urandom();
      @(negedge clk);
      chk("idle", {in_ready, out_valid, tbl_ready, out_data}, 0);
      step();
    end
    in_valid = 0;

    start_load();
    feed(ENTRIES - 1, 0, 0);
    @(negedge clk); chk("load_not_yet", tbl_ready, 0);
    step();
    feed(1, 0, ENTRIES - 1);
    @(negedge clk); chk("loaded", {tbl_ready, cfg_busy}, 2'b10);
    step();

    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_data = lit_in[k]; step(); in_valid = 0;
      @(negedge clk); chk("lut_lit", {out_valid, out_data}, {1'b1, lit_out[k]});
      step();
    end

    acc = 0; cyc = 0; n0 = n_out;
    in_valid = 1; in_data = $urandom();
    while (acc < 8 && cyc < 100) begin
      out_ready = (cyc % 3 == 0);
      @(negedge clk);
      a = in_ready;
      if (a) acc++;
      step(); cyc++;
      if (a) in_data = $urandom();
    end
    in_valid = 0; out_ready = 1;
    step(); step(); step();
    chk("bp_accepts", acc, 8);
    chk("bp_count", n_out - n0, 8);

    start_load(); feed(ENTRIES, 1, 0); step();
    traffic(300);

    out_ready = 0; in_valid = 1; in_data = $urandom(); cfg_start = 1; step();
    in_valid = 0; cfg_start = 0;
    repeat (3) begin
      @(negedge clk); chk("drain_hold", {cfg_busy, tbl_ready, out_valid}, 3'b111);
      step();
    end
    out_ready = 1; step();
    @(negedge clk); chk("after_drain", {cfg_busy, tbl_ready, out_valid}, 3'b100);
    step();
    feed(ENTRIES, 1, 0); step();
    traffic(200);

    start_load(); feed(300, 1, 0);
    cfg_start = 1; cfg_valid = 1; cfg_data = 1; step();
    cfg_start = 0; cfg_valid = 0;
    feed(ENTRIES - 1, 1, 0);
    @(negedge clk); chk("restart_not_yet", tbl_ready, 0);
    step();
    feed(1, 1, 0);
    @(negedge clk); chk("restart_done", tbl_ready, 1);
    step();
    traffic(200);

    start_load(); feed(100, 1, 0);
    cfg_valid = 1;
    #2 rst_n = 0;
    #1 chk("rst_mid_load", {in_ready, out_valid, tbl_ready, cfg_busy, out_data}, 0);
    cfg_valid = 0;
    step(); step(); rst_n = 1;
    for (int k = 0; k < 1100; k++) begin
      cfg_valid = 1; cfg_data = 1'($urandom_range(1)); step();
    end
    cfg_valid = 0;
    @(negedge clk); chk("cfg_ignored", {tbl_ready, cfg_busy, in_ready}, 0);
    step();
    start_load(); feed(ENTRIES, 1, 0); step();
    traffic(300);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lut_neuron_array_ld.md
# lut_neuron_array_ld

Parametrised array of N_CH truth-table neurons, each mapping an IN_BITS-bit input code to an OUT_BITS-bit output through a runtime-loadable table. It replaces fixed per-neuron case-statement ROMs in the generated layer netlists. Tables are streamed in through a configuration port. The datapath is a registered, valid/ready-handshaked stage that sits between adjacent layers of the ensemble pipeline.

## Interface
Parameters:
- IN_BITS, 8, input code width per channel; table depth per channel is 2^IN_BITS
- OUT_BITS, 1, output width per channel
- N_CH, 4, number of independent neurons (channels); must be ≥1
- CW, derived, counter width = $clog2(N_CH) + IN_BITS (for N_CH=1 it is IN_BITS)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- cfg_start  in  1  request a full table (re)load
- cfg_valid  in  1  cfg_data holds the next table entry
- cfg_data  in  OUT_BITS  table entry value
- cfg_busy  out  1  high in DRAIN or LOAD
- tbl_ready  out  1  a complete table is loaded
- in_valid  in  1  in_data valid
- in_ready  out  1  block accepts in_data
- in_data  in  N_CH*IN_BITS  channel c code = in_data[c*IN_BITS +: IN_BITS]
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_data  out  N_CH*OUT_BITS  channel c result = out_data[c*OUT_BITS +: OUT_BITS]

## Operation
- Storage: N_CH × 2^IN_BITS × OUT_BITS registers, distributed-RAM style. Contents are not reset.
- Lookup: result_c = table[c][code_c], where code_c is the unsigned value of the channel's input slice.
- FSM states are IDLE, DRAIN, LOAD and RUN. Reset enters IDLE.
- IDLE: no valid table; in_ready=0. cfg_start → LOAD.
- RUN: cfg_start → DRAIN.
- DRAIN: in_ready=0. Moves to LOAD in the first cycle out_valid is 0, or the cycle its handshake completes.
- LOAD:
  - On entry, the counter clears to 0 and tbl_ready drops to 0.
  - Each cfg_valid cycle writes cfg_data to channel counter[CW-1:IN_BITS], index counter[IN_BITS-1:0], then increments the counter.
  - The write at count N_CH*2^IN_BITS−1 moves the FSM to RUN and sets tbl_ready=1 on the next edge.
- cfg_start during LOAD restarts the counter at 0. A cfg_valid in the same cycle is discarded.
- cfg_valid outside LOAD is ignored. cfg_start in DRAIN is ignored.
- in_ready = (state==RUN) & (!out_valid | out_ready).
- On in_valid & in_ready, out_data is registered from the lookup and out_valid is set.
- out_valid clears when out_valid & out_ready occur without a new accept.
- out_data holds stable while out_valid & !out_ready.

## Timing
- Reset values: state=IDLE, counter=0, tbl_ready=0, cfg_busy=0, in_ready=0, out_valid=0, out_data=0.
- Lookup latency is 1 cycle, from accept edge to out_valid. Throughput is 1 beat per cycle under continuous out_ready.
- in_ready is a function of registered state plus out_ready only. It has no combinational path from in_valid.
- A beat accepted in the same cycle as cfg_start (in RUN) completes normally. DRAIN waits for it to leave.
- A table is never written while a lookup result is pending. Loaded contents take effect for the first beat accepted after RUN is re-entered.
- A full load takes exactly N_CH*2^IN_BITS cfg_valid cycles. Gaps in cfg_valid only stretch the load.
- Reset asserted mid-LOAD or mid-transfer: all outputs take their reset values immediately. The table must be fully reloaded before in_ready rises.
- Counter wrap cannot occur: the terminal count exits LOAD.

## Test plan
- Reset/idle:
  - Stimulus: assert rst_n=0 mid-cycle, then release; drive in_valid=1 for 20 cycles.
  - Required: in_ready=0, out_valid=0, tbl_ready=0 and out_data=0 throughout.
- Load and lookup (defaults):
  - Load: channel c entry i = bit c of i.
  - Stimulus: after exactly 1024 cfg_valid beats, tbl_ready=1 and state=RUN; then send in_data=32'h0F_A5_3C_81.
  - Required: one cycle later out_data=4'b1101, i.e. ch0=1 (81), ch1=0 (3C), ch2=1 (A5), ch3=1 (0F).
- Backpressure:
  - Stimulus: stream 8 beats with out_ready toggling 1,0,0,1,…
  - Required: no beat lost or duplicated; out_data stable while stalled; in_ready low exactly when out_valid & !out_ready.
- Reload with in-flight beat:
  - Stimulus: assert cfg_start together with an accepted beat while out_ready=0 for 3 cycles.
  - Required: DRAIN lasts until that beat's handshake completes. The beat carries the old-table result. LOAD then begins with tbl_ready=0.
- Restart mid-load:
  - Stimulus: after 300 entries, assert cfg_start with cfg_valid=1.
  - Required: that entry is discarded; counter=0; exactly 1024 further entries are needed before tbl_ready=1.
- Reset mid-load:
  - Stimulus: assert rst_n low during LOAD.
  - Required: IDLE; tbl_ready=0; cfg_valid is ignored until the next cfg_start.
